mem_port_requester: RTL and testbench
=====================================

MEM_PORT_REQUESTER -- requirements
Module: mem_port_requester

Interface
REQ-001 SHALL have parameter P_RD_DEPTH, default 4: maximum outstanding reads; power of two, 2..8.
REQ-002 SHALL have ports, in this order:
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous clear
- iLDST_REQ  in  1  upstream request
- oLDST_BUSY  out  1  upstream stall
- iLDST_RW  in  1  1 = write, 0 = read
- iLDST_MASK  in  4  byte mask, 1 = byte disabled
- iLDST_ADDR  in  32  word address
- iLDST_DATA  in  32  write data
- oLDST_VALID  out  1  read data valid
- iLDST_BUSY  in  1  upstream response stall
- oLDST_DATA  out  32  read data
- oMEM_REQ, oMEM_RW, oMEM_MASK[3:0], oMEM_ADDR[31:0], oMEM_DATA[31:0]  out  request to memory interface
- iMEM_BUSY  in  1  memory interface request stall
- iMEM_VALID  in  1  64-bit read return valid
- oMEM_BUSY  out  1  read return stall
- iMEM_DATA  in  64  read return data
- oTIMEOUT  out  1  sticky read watchdog flag; only with the macro in REQ-019

Function
REQ-003 Request register SHALL be one entry; upstream accept = iLDST_REQ && !oLDST_BUSY; memory transfer = oMEM_REQ && !iMEM_BUSY.
REQ-004 On accept, SHALL load rw/mask/addr/data unmodified into the register and set oMEM_REQ the next cycle; the fields SHALL hold stable until transfer.
REQ-005 oLDST_BUSY = (oMEM_REQ && iMEM_BUSY) || (rd_cnt == P_RD_DEPTH); a write is also stalled when rd_cnt is full.
REQ-006 Transfer and accept in the same cycle SHALL reload the register with no bubble; one request per cycle sustained.
REQ-007 rd_cnt SHALL increment on a read accept and decrement on upstream read delivery (oLDST_VALID && !iLDST_BUSY); simultaneous events SHALL leave it unchanged. It SHALL never exceed P_RD_DEPTH or go below 0.
REQ-008 Select queue: P_RD_DEPTH entries of addr[0]; push on read accept, pop on return capture, with wrapping pointers. Capture with the queue empty SHALL be ignored; the data is dropped.
REQ-009 Writes SHALL be posted: no response, no rd_cnt change.
REQ-010 Response register SHALL be one entry; capture = iMEM_VALID && !oMEM_BUSY; oMEM_BUSY = oLDST_VALID && iLDST_BUSY.
REQ-011 Capture SHALL load oLDST_DATA = sel ? iMEM_DATA[63:32] : iMEM_DATA[31:0] and set oLDST_VALID the next cycle.
REQ-012 oLDST_VALID/oLDST_DATA SHALL hold while iLDST_BUSY; delivery and capture in the same cycle SHALL keep valid high with new data.
REQ-013 Read data SHALL be returned in request order.

Reset
REQ-014 inRESET low SHALL asynchronously clear oMEM_REQ, oLDST_VALID, rd_cnt, the queue pointers, the watchdog and oTIMEOUT; data registers SHALL be cleared to 0.
REQ-015 iRESET_SYNC high SHALL apply the same clear at the clock edge, with priority over all other updates; in-flight returns arriving afterwards SHALL be dropped per REQ-008.
REQ-016 After reset oLDST_BUSY SHALL be 0 and oMEM_BUSY SHALL be 0.

Configuration
REQ-017 Macro MEM_PORT_REQUESTER_TIMEOUT_EN SHALL control the read watchdog.
REQ-018 When defined: an 8-bit counter SHALL run while rd_cnt != 0 and reset on every capture or when rd_cnt == 0; on reaching 255 it SHALL set oTIMEOUT, which stays set until a reset.
REQ-019 When undefined: the oTIMEOUT port and the counter SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-020 Single read, addr 0x11, no stalls; return 0xAAAA_BBBB_CCCC_DDDD -> oLDST_DATA = 0xAAAABBBB, one valid pulse.
REQ-021 Read to addr 0x10 with the same return -> 0xCCCCDDDD.
REQ-022 Five back-to-back reads, no returns -> oLDST_BUSY high after the 4th accept; the 5th is accepted the cycle after the first delivery.
REQ-023 iMEM_BUSY held for 3 cycles under a write to 0x40 with mask 0x3 -> oMEM_* stable for 3 cycles, a single transfer, no oLDST_VALID.
REQ-024 iLDST_BUSY held with 2 returns pending -> oMEM_BUSY high, first data held; on release the data is delivered in order on consecutive cycles.
REQ-025 With TIMEOUT_EN, one read and no return for 255 cycles -> oTIMEOUT = 1; iRESET_SYNC -> oTIMEOUT = 0 and rd_cnt = 0.

Source files
------------

// File: rtl/mem_port_requester.sv
// Load/store to 64-bit memory port bridge: one-entry request and response registers
// with in-order read tracking. Define MEM_PORT_REQUESTER_TIMEOUT_EN for the read watchdog.
module mem_port_requester #(
    parameter int P_RD_DEPTH = 4
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iLDST_REQ,
    output logic        oLDST_BUSY,
    input  logic        iLDST_RW,
    input  logic [3:0]  iLDST_MASK,
    input  logic [31:0] iLDST_ADDR,
    input  logic [31:0] iLDST_DATA,
    output logic        oLDST_VALID,
    input  logic        iLDST_BUSY,
    output logic [31:0] oLDST_DATA,
    output logic        oMEM_REQ,
    output logic        oMEM_RW,
    output logic [3:0]  oMEM_MASK,
    output logic [31:0] oMEM_ADDR,
    output logic [31:0] oMEM_DATA,
    input  logic        iMEM_BUSY,
    input  logic        iMEM_VALID,
    output logic        oMEM_BUSY,
    input  logic [63:0] iMEM_DATA
`ifdef MEM_PORT_REQUESTER_TIMEOUT_EN
    ,
    output logic        oTIMEOUT
`endif
);

    localparam int PW = (P_RD_DEPTH > 1) ? $clog2(P_RD_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(P_RD_DEPTH);

    logic          memReq_q,  memReq_d;
    logic          memRw_q,   memRw_d;
    logic [3:0]    memMask_q, memMask_d;
    logic [31:0]   memAddr_q, memAddr_d;
    logic [31:0]   memData_q, memData_d;
    logic [CW-1:0] rdCnt_q,   rdCnt_d;
    logic [CW-1:0] wrPtr_q,   wrPtr_d;
    logic [CW-1:0] rdPtr_q,   rdPtr_d;
    logic          selMem_q [P_RD_DEPTH];
    logic          selMem_d [P_RD_DEPTH];
    logic          ldstValid_q, ldstValid_d;
    logic [31:0]   ldstData_q,  ldstData_d;

    logic accept, rdAccept, transfer, capture, captureOk, deliver, selEmpty, sel;

    assign oLDST_BUSY  = (memReq_q && iMEM_BUSY) || (rdCnt_q == FULL);
    assign oMEM_BUSY   = ldstValid_q && iLDST_BUSY;
    assign accept      = iLDST_REQ && !oLDST_BUSY;
    assign rdAccept    = accept && !iLDST_RW;
    assign transfer    = memReq_q && !iMEM_BUSY;
    assign capture     = iMEM_VALID && !oMEM_BUSY;
    assign deliver     = ldstValid_q && !iLDST_BUSY;
    // Pointers carry an extra wrap bit so equal pointers unambiguously mean empty.
    assign selEmpty    = (wrPtr_q == rdPtr_q);
    assign captureOk   = capture && !selEmpty;
    assign sel         = selMem_q[rdPtr_q[PW-1:0]];

    assign oMEM_REQ    = memReq_q;
    assign oMEM_RW     = memRw_q;
    assign oMEM_MASK   = memMask_q;
    assign oMEM_ADDR   = memAddr_q;
    assign oMEM_DATA   = memData_q;
    assign oLDST_VALID = ldstValid_q;
    assign oLDST_DATA  = ldstData_q;

    always_comb begin
        memReq_d    = memReq_q;
        memRw_d     = memRw_q;
        memMask_d   = memMask_q;
        memAddr_d   = memAddr_q;
        memData_d   = memData_q;
        rdCnt_d     = rdCnt_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        selMem_d    = selMem_q;
        ldstValid_d = ldstValid_q;
        ldstData_d  = ldstData_q;

        if (accept) begin
            memReq_d  = 1'b1;
            memRw_d   = iLDST_RW;
            memMask_d = iLDST_MASK;
            memAddr_d = iLDST_ADDR;
            memData_d = iLDST_DATA;
        end else if (transfer) begin
            memReq_d = 1'b0;
        end

        if (rdAccept) begin
            selMem_d[wrPtr_q[PW-1:0]] = iLDST_ADDR[0];
            wrPtr_d = wrPtr_q + CW'(1);
        end

        case ({rdAccept, deliver && (rdCnt_q != '0)})
            2'b10:   rdCnt_d = rdCnt_q + CW'(1);
            2'b01:   rdCnt_d = rdCnt_q - CW'(1);
            default: rdCnt_d = rdCnt_q;
        endcase

        if (captureOk) begin
            rdPtr_d     = rdPtr_q + CW'(1);
            ldstValid_d = 1'b1;
            ldstData_d  = sel ? iMEM_DATA[63:32] : iMEM_DATA[31:0];
        end else if (deliver) begin
            ldstValid_d = 1'b0;
        end

        // Synchronous clear overrides every update above.
        if (iRESET_SYNC) begin
            memReq_d    = 1'b0;
            memRw_d     = 1'b0;
            memMask_d   = '0;
            memAddr_d   = '0;
            memData_d   = '0;
            rdCnt_d     = '0;
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            ldstValid_d = 1'b0;
            ldstData_d  = '0;
            for (int i = 0; i < P_RD_DEPTH; i++) selMem_d[i] = 1'b0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            memReq_q    <= 1'b0;
            memRw_q     <= 1'b0;
            memMask_q   <= '0;
            memAddr_q   <= '0;
            memData_q   <= '0;
            rdCnt_q     <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            ldstValid_q <= 1'b0;
            ldstData_q  <= '0;
            for (int i = 0; i < P_RD_DEPTH; i++) selMem_q[i] <= 1'b0;
        end else begin
            memReq_q    <= memReq_d;
            memRw_q     <= memRw_d;
            memMask_q   <= memMask_d;
            memAddr_q   <= memAddr_d;
            memData_q   <= memData_d;
            rdCnt_q     <= rdCnt_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            ldstValid_q <= ldstValid_d;
            ldstData_q  <= ldstData_d;
            selMem_q    <= selMem_d;
        end
    end

`ifdef MEM_PORT_REQUESTER_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
    logic       timeout_q, timeout_d;

    // Counts cycles without a return while reads are outstanding; the flag is sticky.
    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (capture || (rdCnt_q == '0)) begin
            wd_d = 8'd0;
        end else if (wd_q != 8'hFF) begin
            wd_d = wd_q + 8'd1;
        end
        if (wd_d == 8'hFF) timeout_d = 1'b1;
        if (iRESET_SYNC) begin
            wd_d      = 8'd0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wd_q      <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign oTIMEOUT = timeout_q;
`endif

endmodule

// File: tb/tb_mem_port_requester.sv
// Self-checking bench for mem_port_requester: directed scenarios then randomized traffic,
// all checked against a queue-based transaction model.
module tb_mem_port_requester;

    localparam int DEPTH = 4;

    logic        iCLOCK, inRESET, iRESET_SYNC;
    logic        iLDST_REQ, oLDST_BUSY, iLDST_RW;
    logic [3:0]  iLDST_MASK;
    logic [31:0] iLDST_ADDR, iLDST_DATA;
    logic        oLDST_VALID, iLDST_BUSY;
    logic [31:0] oLDST_DATA;
    logic        oMEM_REQ, oMEM_RW;
    logic [3:0]  oMEM_MASK;
    logic [31:0] oMEM_ADDR, oMEM_DATA;
    logic        iMEM_BUSY, iMEM_VALID, oMEM_BUSY;
    logic [63:0] iMEM_DATA;
`ifdef MEM_PORT_REQUESTER_TIMEOUT_EN
    logic        oTIMEOUT;
`endif

    mem_port_requester #(.P_RD_DEPTH(DEPTH)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
        .iLDST_REQ(iLDST_REQ), .oLDST_BUSY(oLDST_BUSY), .iLDST_RW(iLDST_RW),
        .iLDST_MASK(iLDST_MASK), .iLDST_ADDR(iLDST_ADDR), .iLDST_DATA(iLDST_DATA),
        .oLDST_VALID(oLDST_VALID), .iLDST_BUSY(iLDST_BUSY), .oLDST_DATA(oLDST_DATA),
        .oMEM_REQ(oMEM_REQ), .oMEM_RW(oMEM_RW), .oMEM_MASK(oMEM_MASK),
        .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA), .iMEM_BUSY(iMEM_BUSY),
        .iMEM_VALID(iMEM_VALID), .oMEM_BUSY(oMEM_BUSY), .iMEM_DATA(iMEM_DATA)
`ifdef MEM_PORT_REQUESTER_TIMEOUT_EN
        , .oTIMEOUT(oTIMEOUT)
`endif
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    typedef struct packed {
        logic        rw;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    // Model: pending memory request, address parity of reads awaiting return,
    // captured data awaiting delivery, and read counts.
    req_t        reqQ[$];
    logic        selQ[$];
    logic [31:0] respQ[$];
    int          outstanding;
    int          memPending;
    int          nCompared;
    int          nMismatch;
    logic        acc, cap;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs, advance the model.
    task automatic applyStimulus(input logic req, input logic rw, input logic [3:0] mask,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic memBusy, input logic memValid, input logic [63:0] memData,
                                 input logic ldstBusy, input logic syncRst,
                                 output logic accOut, output logic capOut);
        logic  expBusy, expMemBusy, xfer, dlv, s;
        req_t  r;
        logic [31:0] dummy;
        iLDST_REQ = req; iLDST_RW = rw; iLDST_MASK = mask; iLDST_ADDR = addr; iLDST_DATA = data;
        iMEM_BUSY = memBusy; iMEM_VALID = memValid; iMEM_DATA = memData;
        iLDST_BUSY = ldstBusy; iRESET_SYNC = syncRst;
        #1;
        expBusy    = ((reqQ.size() != 0) && memBusy) || (outstanding == DEPTH);
        expMemBusy = (respQ.size() != 0) && ldstBusy;
        checkOutput("ldst_busy", 64'(oLDST_BUSY), 64'(expBusy));
        checkOutput("mem_busy", 64'(oMEM_BUSY), 64'(expMemBusy));
        checkOutput("mem_req", 64'(oMEM_REQ), 64'(reqQ.size() != 0));
        if (reqQ.size() != 0) begin
            checkOutput("mem_rw", 64'(oMEM_RW), 64'(reqQ[0].rw));
            checkOutput("mem_mask", 64'(oMEM_MASK), 64'(reqQ[0].mask));
            checkOutput("mem_addr", 64'(oMEM_ADDR), 64'(reqQ[0].addr));
            checkOutput("mem_data", 64'(oMEM_DATA), 64'(reqQ[0].data));
        end
        checkOutput("ldst_valid", 64'(oLDST_VALID), 64'(respQ.size() != 0));
        if (respQ.size() != 0) checkOutput("ldst_data", 64'(oLDST_DATA), 64'(respQ[0]));
        accOut = req && !expBusy;
        capOut = memValid && !expMemBusy;
        xfer   = (reqQ.size() != 0) && !memBusy;
        dlv    = (respQ.size() != 0) && !ldstBusy;
        if (syncRst) begin
            reqQ.delete(); selQ.delete(); respQ.delete();
            outstanding = 0; memPending = 0;
            accOut = 1'b0; capOut = 1'b0;
        end else begin
            if (dlv) begin
                dummy = respQ.pop_front();
                outstanding--;
            end
            if (capOut && selQ.size() != 0) begin
                s = selQ.pop_front();
                respQ.push_back(s ? memData[63:32] : memData[31:0]);
                if (memPending > 0) memPending--;
            end
            if (xfer) begin
                r = reqQ.pop_front();
                if (!r.rw) memPending++;
            end
            if (accOut) begin
                reqQ.push_back('{rw, mask, addr, data});
                if (!rw) begin
                    selQ.push_back(addr[0]);
                    outstanding++;
                end
            end
        end
        @(posedge iCLOCK);
        @(negedge iCLOCK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 64'h0, 0, 0, acc, cap);
    endtask

    // Return every outstanding read and drain responses, within a cycle budget.
    task automatic drain();
        int k;
        k = 0;
        while ((outstanding != 0 || reqQ.size() != 0 || respQ.size() != 0) && k < 200) begin
            applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, memPending > 0, {$urandom, $urandom}, 0, 0, acc, cap);
            k++;
        end
        checkOutput("drain_done", 64'(outstanding), 64'(0));
    endtask

    initial begin
        int accIdx, dlvIdx;
        logic mv, ldB, sr;
        logic [63:0] md;
        nCompared = 0; nMismatch = 0; outstanding = 0; memPending = 0;
        inRESET = 1'b0; iRESET_SYNC = 0; iLDST_REQ = 0; iLDST_RW = 0; iLDST_MASK = 0;
        iLDST_ADDR = 0; iLDST_DATA = 0; iLDST_BUSY = 0; iMEM_BUSY = 0; iMEM_VALID = 0; iMEM_DATA = 0;
        repeat (2) @(negedge iCLOCK);
        checkOutput("rst_mem_req", 64'(oMEM_REQ), 64'(0));
        checkOutput("rst_ldst_valid", 64'(oLDST_VALID), 64'(0));
        checkOutput("rst_ldst_busy", 64'(oLDST_BUSY), 64'(0));
        checkOutput("rst_mem_busy", 64'(oMEM_BUSY), 64'(0));
        checkOutput("rst_ldst_data", 64'(oLDST_DATA), 64'(0));
        checkOutput("rst_mem_addr", 64'(oMEM_ADDR), 64'(0));
        inRESET = 1'b1;
        idle(2);

        $display("[TB] single reads, odd and even word");
        applyStimulus(1, 0, 4'h0, 32'h11, 32'h0, 0, 0, 64'h0, 0, 0, acc, cap);
        checkOutput("r20_addr", 64'(oMEM_ADDR), 64'h11);
        idle(1);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, acc, cap);
        checkOutput("r20_valid", 64'(oLDST_VALID), 64'(1));
        checkOutput("r20_data", 64'(oLDST_DATA), 64'hAAAABBBB);
        idle(1);
        checkOutput("r20_pulse", 64'(oLDST_VALID), 64'(0));
        applyStimulus(1, 0, 4'h0, 32'h10, 32'h0, 0, 0, 64'h0, 0, 0, acc, cap);
        idle(1);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, acc, cap);
        checkOutput("r21_data", 64'(oLDST_DATA), 64'hCCCCDDDD);
        idle(1);

        $display("[TB] read depth limit");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 4'h0, 32'h100 + i, 32'h0, 0, 0, 64'h0, 0, 0, acc, cap);
        iLDST_REQ = 1'b1; iLDST_ADDR = 32'h104;
        #1;
        checkOutput("r22_busy_full", 64'(oLDST_BUSY), 64'(1));
        accIdx = -1; dlvIdx = -1;
        for (int c = 0; c < 20 && accIdx < 0; c++) begin
            if (respQ.size() != 0 && dlvIdx < 0) dlvIdx = c;
            applyStimulus(1, 0, 4'h0, 32'h104, 32'h0, 0, (memPending > 0) && (dlvIdx < 0) && (respQ.size() == 0),
                          64'h1111_2222_3333_4444, 0, 0, acc, cap);
            if (acc) accIdx = c;
        end
        checkOutput("r22_fifth_accept", 64'(accIdx), 64'(dlvIdx + 1));
        drain();

        $display("[TB] stalled write");
        applyStimulus(1, 1, 4'h3, 32'h40, 32'hDEADBEEF, 0, 0, 64'h0, 0, 0, acc, cap);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 64'h0, 0, 0, acc, cap);
            checkOutput("r23_addr_hold", 64'(oMEM_ADDR), 64'h40);
            checkOutput("r23_mask_hold", 64'(oMEM_MASK), 64'h3);
        end
        idle(1);
        checkOutput("r23_single", 64'(oMEM_REQ), 64'(0));
        idle(2);
        checkOutput("r23_no_resp", 64'(oLDST_VALID), 64'(0));

        $display("[TB] response stall");
        applyStimulus(1, 0, 4'h0, 32'h21, 32'h0, 0, 0, 64'h0, 0, 0, acc, cap);
        applyStimulus(1, 0, 4'h0, 32'h30, 32'h0, 0, 0, 64'h0, 0, 0, acc, cap);
        idle(1);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 64'h0101_0101_0202_0202, 1, 0, acc, cap);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 64'h0303_0303_0404_0404, 1, 0, acc, cap);
            checkOutput("r24_mem_busy", 64'(oMEM_BUSY), 64'(1));
            checkOutput("r24_hold", 64'(oLDST_DATA), 64'h01010101);
        end
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 64'h0303_0303_0404_0404, 0, 0, acc, cap);
        checkOutput("r24_second_valid", 64'(oLDST_VALID), 64'(1));
        checkOutput("r24_second_data", 64'(oLDST_DATA), 64'h04040404);
        idle(1);
        checkOutput("r24_done", 64'(oLDST_VALID), 64'(0));

        $display("[TB] synchronous clear drops late returns");
        applyStimulus(1, 0, 4'h0, 32'h51, 32'h0, 0, 0, 64'h0, 0, 0, acc, cap);
        applyStimulus(1, 0, 4'h0, 32'h52, 32'h0, 0, 0, 64'h0, 0, 0, acc, cap);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 64'h0, 0, 1, acc, cap);
        checkOutput("sr_mem_req", 64'(oMEM_REQ), 64'(0));
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 64'hFFFF_EEEE_DDDD_CCCC, 0, 0, acc, cap);
        checkOutput("sr_dropped", 64'(oLDST_VALID), 64'(0));
        checkOutput("sr_data_clear", 64'(oLDST_DATA), 64'(0));

`ifdef MEM_PORT_REQUESTER_TIMEOUT_EN
        $display("[TB] read watchdog");
        applyStimulus(1, 0, 4'h0, 32'h7, 32'h0, 0, 0, 64'h0, 0, 0, acc, cap);
        idle(100);
        checkOutput("to_early", 64'(oTIMEOUT), 64'(0));
        idle(200);
        checkOutput("to_set", 64'(oTIMEOUT), 64'(1));
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 64'h0, 0, 1, acc, cap);
        checkOutput("to_clear", 64'(oTIMEOUT), 64'(0));
        checkOutput("to_busy", 64'(oLDST_BUSY), 64'(0));
`endif

        $display("[TB] randomized traffic");
        mv = 1'b0; md = 64'h0;
        for (int i = 0; i < 3000; i++) begin
            if (!mv && memPending > 0 && ($urandom % 2 == 1)) begin
                mv = 1'b1;
                md = {$urandom, $urandom};
            end
            ldB = ($urandom % 4 == 0);
            sr  = ($urandom % 300 == 0);
            applyStimulus($urandom % 2 == 1, $urandom % 3 == 0, 4'($urandom), $urandom, $urandom,
                          $urandom % 4 == 0, mv, md, ldB, sr, acc, cap);
            if (cap || sr) mv = 1'b0;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
